burst_data_medium: RTL and testbench

- Parametrised successor to the single-sample data medium. Streams a burst of consecutive samples out of one BRAM port.
- Each sample is FIELDS fields of PIECES BRAM words. x/y is the FIELDS=2 case.
- Read-only. Sits between the CPU/trainer and a read-latency-configurable BRAM.
- Adds burst length, valid/ready backpressure, a double buffer (assembly + output) and configurable BRAM latency.

---
 rtl/burst_data_medium.sv | 235 +++++++++++++++++++++++
 tb/tb_burst_data_medium.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_data_medium.sv
// burst_data_medium: streams a burst of consecutive samples out of one read-only BRAM port.
// Each sample is FIELDS fields of PIECES BRAM words (WORDS in total). Words are issued one per
// cycle, come back after BRAM_LATENCY cycles into an assembly buffer, and then move to an
// output register that supports valid/ready backpressure.
//
// Optional feature: define BURST_DATA_MEDIUM_WRAP_EN to accept bursts that run past the end of
// the sample store. The sample index then wraps from ADDRS-1 to 0.
//
// Ports:
//   clk_in, rst_in         clock, synchronous active-high reset
//   addr_in, len_in        first sample index and sample count of the burst
//   read_enable, ready_out start request, accepted while idle
//   data_out, valid_out    current sample (field 0 in the MSBs) and its valid flag
//   data_ready_in          consumer accepts data_out when valid_out is high
//   last_out               data_out is the final sample of the burst
//   finished_out           one-cycle pulse after the final sample is accepted
//   error_out              one-cycle pulse when a request is rejected
//   bram_*                 BRAM read port (write side tied off)
module burst_data_medium #(
  parameter int unsigned ADDRS        = 1024,
  parameter int unsigned BRAM_WIDTH   = 64,
  parameter int unsigned PIECES       = 16,
  parameter int unsigned FIELDS       = 2,
  parameter int unsigned BRAM_LATENCY = 2,
  localparam int unsigned WORDS          = FIELDS * PIECES,
  localparam int unsigned ADDR_SIZE      = $clog2(ADDRS),
  localparam int unsigned BRAM_ADDR_SIZE = $clog2(ADDRS * WORDS),
  localparam int unsigned SAMPLE_WIDTH   = WORDS * BRAM_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [ADDR_SIZE-1:0]      addr_in,
  input  logic [ADDR_SIZE:0]        len_in,
  input  logic                      read_enable,
  output logic                      ready_out,
  output logic [SAMPLE_WIDTH-1:0]   data_out,
  output logic                      valid_out,
  input  logic                      data_ready_in,
  output logic                      last_out,
  output logic                      finished_out,
  output logic                      error_out,
  input  logic [BRAM_WIDTH-1:0]     bram_dout,
  output logic [BRAM_ADDR_SIZE-1:0] bram_addr,
  output logic                      bram_we,
  output logic                      bram_regce,
  output logic [BRAM_WIDTH-1:0]     bram_din
);

  localparam int unsigned IW  = ADDR_SIZE + 1;
  localparam int unsigned WCW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCW-1:0] WordMax = WCW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e                              state_q, state_d;
  logic [IW-1:0]                       len_q, len_d;
  logic [IW-1:0]                       sample_q, sample_d;
  logic [IW-1:0]                       issued_q, issued_d;
  logic [WCW-1:0]                      word_q, word_d;
  logic [WCW-1:0]                      rcv_q, rcv_d;
  logic [1:0]                          pend_q, pend_d;
  logic [BRAM_LATENCY-1:0]             pipe_vld_q, pipe_vld_d;
  logic [BRAM_LATENCY-1:0]             pipe_last_q, pipe_last_d;
  logic [WORDS-1:0][BRAM_WIDTH-1:0]    asm_q, asm_d;
  logic                                asm_full_q, asm_full_d;
  logic                                asm_last_q, asm_last_d;
  logic [SAMPLE_WIDTH-1:0]             data_q, data_d;
  logic                                valid_q, valid_d;
  logic                                last_q, last_d;
  logic                                finished_q, finished_d;
  logic                                error_q, error_d;

  logic issue, issue_start, issue_last, cap, xfer, accept, bad_len, req_bad;

  assign bad_len = (len_in == '0) || (len_in > IW'(ADDRS));
`ifdef BURST_DATA_MEDIUM_WRAP_EN
  assign req_bad = bad_len;
`else
  logic [IW:0] req_end;
  assign req_end = {2'b00, addr_in} + {1'b0, len_in};
  assign req_bad = bad_len || (req_end > (IW + 1)'(ADDRS));
`endif

  // pend_q counts samples issued but not yet moved to the output register. A new sample may
  // start while the previous one is still filling only if the output register is empty: then
  // the previous sample is guaranteed to move out on the very edge the new word 0 lands.
  assign issue = (state_q == StFetch) &&
                 ((word_q != '0) || (pend_q == 2'd0) || ((pend_q == 2'd1) && !valid_q));
  assign issue_start = issue && (word_q == '0);
  assign issue_last  = (issued_q == len_q - IW'(1));
  assign cap         = pipe_vld_q[BRAM_LATENCY-1];
  assign xfer        = asm_full_q && (!valid_q || data_ready_in);
  assign accept      = valid_q && data_ready_in;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sample_d    = sample_q;
    issued_d    = issued_q;
    word_d      = word_q;
    rcv_d       = rcv_q;
    pend_d      = pend_q;
    asm_d       = asm_q;
    asm_last_d  = asm_last_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    finished_d  = 1'b0;
    error_d     = 1'b0;
    pipe_vld_d  = '0;
    pipe_last_d = '0;

    // Valid and last tags travel alongside each issued address for BRAM_LATENCY cycles.
    pipe_vld_d[0]  = issue;
    pipe_last_d[0] = issue && issue_last;
    for (int i = 1; i < BRAM_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end

    if (issue) begin
      if (word_q == WordMax) begin
        word_d   = '0;
        issued_d = issued_q + IW'(1);
        sample_d = (sample_q == IW'(ADDRS - 1)) ? '0 : sample_q + IW'(1);
        if (issue_last) state_d = StDrain;
      end else begin
        word_d = word_q + WCW'(1);
      end
    end

    // Word j of a sample lands in slot WORDS-1-j so that word 0 ends up in the MSBs.
    if (cap) begin
      asm_d[WordMax - rcv_q] = bram_dout;
      if (rcv_q == WordMax) begin
        rcv_d      = '0;
        asm_last_d = pipe_last_q[BRAM_LATENCY-1];
      end else begin
        rcv_d = rcv_q + WCW'(1);
      end
    end
    asm_full_d = (asm_full_q && !xfer) || (cap && (rcv_q == WordMax));

    unique case ({issue_start, xfer})
      2'b10:   pend_d = pend_q + 2'd1;
      2'b01:   pend_d = pend_q - 2'd1;
      default: pend_d = pend_q;
    endcase

    if (xfer) begin
      data_d  = asm_q;
      valid_d = 1'b1;
      last_d  = asm_last_q;
    end else if (accept) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (read_enable) begin
          if (req_bad) begin
            error_d = 1'b1;
          end else begin
            len_d    = len_in;
            sample_d = {1'b0, addr_in};
            issued_d = '0;
            word_d   = '0;
            state_d  = StFetch;
          end
        end
      end
      StFetch: ;
      StDrain: begin
        if (accept && last_q) begin
          finished_d = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      len_q       <= '0;
      sample_q    <= '0;
      issued_q    <= '0;
      word_q      <= '0;
      rcv_q       <= '0;
      pend_q      <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      asm_q       <= '0;
      asm_full_q  <= 1'b0;
      asm_last_q  <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      finished_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sample_q    <= sample_d;
      issued_q    <= issued_d;
      word_q      <= word_d;
      rcv_q       <= rcv_d;
      pend_q      <= pend_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      asm_q       <= asm_d;
      asm_full_q  <= asm_full_d;
      asm_last_q  <= asm_last_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      finished_q  <= finished_d;
      error_q     <= error_d;
    end
  end

  assign ready_out    = (state_q == StIdle);
  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign last_out     = last_q;
  assign finished_out = finished_q;
  assign error_out    = error_q;
  assign bram_addr    = issue ? BRAM_ADDR_SIZE'(32'(sample_q) * WORDS + 32'(word_q)) : '0;
  assign bram_we      = 1'b0;
  assign bram_regce   = 1'b1;
  assign bram_din     = '0;

endmodule

// File: tb/tb_burst_data_medium.sv
// Self-checking bench for burst_data_medium: a default-parameter instance driven from a vector
// table plus hand-written sequences, and two small instances (FIELDS=3, PIECES=4) at BRAM
// latencies 1 and 4. Each BRAM model returns its own read address as data.
module tb_burst_data_medium;

  localparam int WORDS = 32;
  localparam int LAT   = 2;
  localparam int ADDRS = 1024;
  localparam int SW    = 2048;
  localparam int SWS   = 192;

  logic clk, rst, s_rst;

  // Default instance signals
  logic [9:0]    addr;
  logic [10:0]   len;
  logic          re, rdy, ready, valid, last, fin, err, bwe, bregce;
  logic [SW-1:0] data;
  logic [63:0]   bdout, bdin;
  logic [14:0]   baddr;
  logic [14:0]   mpipe [LAT];

  // Small instance signals (shared stimulus)
  logic [3:0]     s_addr;
  logic [4:0]     s_len;
  logic           s_re, s_rdy;
  logic           a_ready, a_valid, a_last, a_fin, a_err, a_we, a_regce;
  logic           b_ready, b_valid, b_last, b_fin, b_err, b_we, b_regce;
  logic [SWS-1:0] a_data, b_data;
  logic [15:0]    a_bdout, a_bdin, b_bdout, b_bdin;
  logic [7:0]     a_baddr, b_baddr, apipe;
  logic [7:0]     bpipe [4];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int addr;
    int len;
    bit bad;
    int first;
  } vec_t;
  vec_t vecs [8];

  burst_data_medium u_dut (
    .clk_in(clk), .rst_in(rst), .addr_in(addr), .len_in(len), .read_enable(re),
    .ready_out(ready), .data_out(data), .valid_out(valid), .data_ready_in(rdy),
    .last_out(last), .finished_out(fin), .error_out(err), .bram_dout(bdout),
    .bram_addr(baddr), .bram_we(bwe), .bram_regce(bregce), .bram_din(bdin)
  );

  burst_data_medium #(
    .ADDRS(16), .BRAM_WIDTH(16), .PIECES(4), .FIELDS(3), .BRAM_LATENCY(1)
  ) u_l1 (
    .clk_in(clk), .rst_in(s_rst), .addr_in(s_addr), .len_in(s_len), .read_enable(s_re),
    .ready_out(a_ready), .data_out(a_data), .valid_out(a_valid), .data_ready_in(s_rdy),
    .last_out(a_last), .finished_out(a_fin), .error_out(a_err), .bram_dout(a_bdout),
    .bram_addr(a_baddr), .bram_we(a_we), .bram_regce(a_regce), .bram_din(a_bdin)
  );

  burst_data_medium #(
    .ADDRS(16), .BRAM_WIDTH(16), .PIECES(4), .FIELDS(3), .BRAM_LATENCY(4)
  ) u_l4 (
    .clk_in(clk), .rst_in(s_rst), .addr_in(s_addr), .len_in(s_len), .read_enable(s_re),
    .ready_out(b_ready), .data_out(b_data), .valid_out(b_valid), .data_ready_in(s_rdy),
    .last_out(b_last), .finished_out(b_fin), .error_out(b_err), .bram_dout(b_bdout),
    .bram_addr(b_baddr), .bram_we(b_we), .bram_regce(b_regce), .bram_din(b_bdin)
  );

  // BRAM models: data word equals its address, delayed by the configured latency.
  always_ff @(posedge clk) begin
    mpipe[0] <= baddr;
    mpipe[1] <= mpipe[0];
    apipe    <= a_baddr;
    bpipe[0] <= b_baddr;
    for (int i = 1; i < 4; i++) bpipe[i] <= bpipe[i-1];
  end
  assign bdout   = {49'b0, mpipe[LAT-1]};
  assign a_bdout = {8'b0, apipe};
  assign b_bdout = {8'b0, bpipe[3]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, vectors %0d miscompares %0d", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [SW-1:0] exp_main(input int s);
    logic [SW-1:0] v = '0;
    for (int j = 0; j < WORDS; j++) v[(WORDS-j)*64-1 -: 64] = 64'(s * WORDS + j);
    return v;
  endfunction

  function automatic logic [SWS-1:0] exp_small(input int s);
    logic [SWS-1:0] v = '0;
    for (int j = 0; j < 12; j++) v[(12-j)*16-1 -: 16] = 16'(s * 12 + j);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [SW-1:0] act,
                            input logic [SW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got msw %0h lsw %0h expected msw %0h lsw %0h", name,
               act[SW-1 -: 64], act[63:0], exp[SW-1 -: 64], exp[63:0]);
    end
  endtask

  task automatic run_vec(input int a, input int l, input bit bad, input int first);
    int  cyc, k, prev, extra;
    bit  done;
    @(negedge clk);
    addr = 10'(a); len = 11'(l); re = 1'b1; rdy = 1'b1;
    @(negedge clk);
    re = 1'b0;
    if (bad) begin
      check("rej_err", 64'(err), 64'd1);
      check("rej_ready", 64'(ready), 64'd1);
      @(negedge clk);
      check("rej_err_pulse", 64'(err), 64'd0);
      check("rej_idle", 64'(ready), 64'd1);
      return;
    end
    check("acc_ready_low", 64'(ready), 64'd0);
    check("acc_err", 64'(err), 64'd0);
    cyc = 1; k = 0; prev = 0; extra = 0; done = 1'b0;
    while (!done && cyc < 80 + 40 * l) begin
      if (fin) extra++;
      if (valid) begin
        check_data("sample", data, exp_main((a + k) % ADDRS));
        check("last", 64'(last), 64'(k == l - 1));
        if (k == 0) check("first_lat", 64'(cyc), 64'(first));
        else        check("spacing", 64'(cyc - prev), 64'(WORDS));
        prev = cyc;
        k++;
        if (k == l) begin
          @(negedge clk);
          check("fin_pulse", 64'(fin), 64'd1);
          check("done_ready", 64'(ready), 64'd1);
          check("done_valid", 64'(valid), 64'd0);
          @(negedge clk);
          check("fin_one", 64'(fin), 64'd0);
          done = 1'b1;
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL timeout: got %0d samples expected %0d", k, l);
    end
    check("extra_fin", 64'(extra), 64'd0);
  endtask

  task automatic backpressure();
    int         k, bad_data, changes;
    bit         seen;
    logic [14:0] prev_addr;
    @(negedge clk);
    addr = 10'd100; len = 11'd3; re = 1'b1; rdy = 1'b0;
    @(negedge clk);
    re = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      if (valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("bp_first", 64'(seen), 64'd1);
    bad_data = 0; changes = 0; prev_addr = baddr;
    for (int c = 0; c < 100; c++) begin
      if (!valid || last || data !== exp_main(100)) bad_data++;
      if (c > 40 && baddr !== prev_addr) changes++;
      prev_addr = baddr;
      @(negedge clk);
    end
    check("bp_hold", 64'(bad_data), 64'd0);
    check("bp_bram_idle", 64'(changes), 64'd0);
    rdy = 1'b1;
    k = 0;
    for (int c = 0; c < 200 && k < 3; c++) begin
      if (valid) begin
        check_data("bp_sample", data, exp_main(100 + k));
        check("bp_last", 64'(last), 64'(k == 2));
        k++;
      end
      @(negedge clk);
    end
    check("bp_count", 64'(k), 64'd3);
    check("bp_fin", 64'(fin), 64'd1);
  endtask

  task automatic reset_mid();
    int k, stale;
    bit fired;
    @(negedge clk);
    addr = 10'd50; len = 11'd5; re = 1'b1; rdy = 1'b1;
    @(negedge clk);
    re = 1'b0;
    k = 0; fired = 1'b0;
    for (int c = 0; c < 200 && !fired; c++) begin
      if (valid) k++;
      if (k == 2) fired = 1'b1;
      else @(negedge clk);
    end
    check("rst_reach", 64'(fired), 64'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_last", 64'(last), 64'd0);
    check_data("rst_data", data, '0);
    stale = 0;
    repeat (80) begin
      @(negedge clk);
      if (valid || fin || err) stale++;
    end
    check("rst_no_stale", 64'(stale), 64'd0);
    run_vec(0, 1, 1'b0, 1 + WORDS + LAT + 1);
  endtask

  task automatic sweep();
    int ka, kb;
    @(negedge clk);
    s_addr = 4'd5; s_len = 5'd2; s_re = 1'b1; s_rdy = 1'b1;
    @(negedge clk);
    s_re = 1'b0;
    ka = 0; kb = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (a_valid) begin
        check_data("l1_sample", SW'(a_data), SW'(exp_small(5 + ka)));
        check("l1_last", 64'(a_last), 64'(ka == 1));
        check("l1_time", 64'(cyc), 64'(1 + 12 + 1 + 1 + 12 * ka));
        ka++;
      end
      if (b_valid) begin
        check_data("l4_sample", SW'(b_data), SW'(exp_small(5 + kb)));
        check("l4_last", 64'(b_last), 64'(kb == 1));
        check("l4_time", 64'(cyc), 64'(1 + 12 + 4 + 1 + 12 * kb));
        kb++;
      end
      @(negedge clk);
    end
    check("l1_count", 64'(ka), 64'd2);
    check("l4_count", 64'(kb), 64'd2);
    check("l1_idle", 64'(a_ready), 64'd1);
    check("l4_idle", 64'(b_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; s_rst = 1'b1; re = 1'b0; s_re = 1'b0; rdy = 1'b1; s_rdy = 1'b1;
    addr = '0; len = '0; s_addr = '0; s_len = '0;
    repeat (3) @(negedge clk);
    check("rst0_ready", 64'(ready), 64'd1);
    check("rst0_valid", 64'(valid), 64'd0);
    check("rst0_last", 64'(last), 64'd0);
    check("rst0_fin", 64'(fin), 64'd0);
    check("rst0_err", 64'(err), 64'd0);
    check("rst0_baddr", 64'(baddr), 64'd0);
    check_data("rst0_data", data, '0);
    check("tie_we", 64'({bwe, a_we, b_we}), 64'd0);
    check("tie_regce", 64'({bregce, a_regce, b_regce}), 64'd7);
    check("tie_din", 64'(bdin | 64'(a_bdin) | 64'(b_bdin)), 64'd0);
    check("rst0_small_err", 64'({a_err, a_fin, b_err, b_fin}), 64'd0);
    rst = 1'b0; s_rst = 1'b0;

    vecs[0] = '{addr: 3,    len: 1,    bad: 1'b0, first: 36};
    vecs[1] = '{addr: 10,   len: 4,    bad: 1'b0, first: 36};
`ifdef BURST_DATA_MEDIUM_WRAP_EN
    vecs[2] = '{addr: 1020, len: 8,    bad: 1'b0, first: 36};
    vecs[7] = '{addr: 1021, len: 4,    bad: 1'b0, first: 36};
`else
    vecs[2] = '{addr: 1020, len: 8,    bad: 1'b1, first: 0};
    vecs[7] = '{addr: 1021, len: 4,    bad: 1'b1, first: 0};
`endif
    vecs[3] = '{addr: 5,    len: 0,    bad: 1'b1, first: 0};
    vecs[4] = '{addr: 0,    len: 1025, bad: 1'b1, first: 0};
    vecs[5] = '{addr: 1023, len: 1,    bad: 1'b0, first: 36};
    vecs[6] = '{addr: 1020, len: 4,    bad: 1'b0, first: 36};

    for (int i = 0; i < 8; i++) run_vec(vecs[i].addr, vecs[i].len, vecs[i].bad, vecs[i].first);

    backpressure();
    reset_mid();
    sweep();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
